// File: rtl/fetch_stage.sv
// Instruction fetch front end: single-outstanding imem reads feeding a
// 2-entry {pc, instruction} queue that presents its head to decode.
module fetch_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        jump_i,
    input  logic [15:0] new_pc_i,
    input  logic        stall_i,
    output logic        imem_req_o,
    output logic [15:0] imem_addr_o,
    input  logic        imem_valid_i,
    input  logic [15:0] imem_rdata_i,
    output logic [15:0] pc_out_o,
    output logic [15:0] ir_out_o,
    output logic        valid_out_o
);

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_DROP  = 2'd2;

    logic [1:0]  state_q,    state_d;
    logic [15:0] fetch_pc_q, fetch_pc_d;
    logic [15:0] req_pc_q,   req_pc_d;
    logic [1:0]  cnt_q,      cnt_d;
    logic [15:0] q_pc_q [2];
    logic [15:0] q_pc_d [2];
    logic [15:0] q_ir_q [2];
    logic [15:0] q_ir_d [2];

    logic pop, push, issue;
    logic [1:0] wr_pos;

    assign valid_out_o = (cnt_q != 2'd0);
    assign pop         = valid_out_o && !stall_i;
    assign push        = (state_q == S_WAIT) && imem_valid_i && !jump_i;
    // Occupancy gating here is what keeps a response from landing in a full queue.
    assign issue       = (state_q == S_FETCH) && !jump_i && !reset_i && (cnt_q < 2'd2);
    assign wr_pos      = cnt_q - {1'b0, pop};

    assign imem_req_o  = issue;
    assign imem_addr_o = fetch_pc_q;
    assign pc_out_o    = valid_out_o ? q_pc_q[0] : 16'h0000;
    assign ir_out_o    = valid_out_o ? q_ir_q[0] : 16'h0000;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        cnt_d      = cnt_q;
        q_pc_d     = q_pc_q;
        q_ir_d     = q_ir_q;
        if (jump_i) begin
            cnt_d      = 2'd0;
            fetch_pc_d = new_pc_i;
            if (state_q == S_WAIT)
                state_d = imem_valid_i ? S_FETCH : S_DROP;
        end else begin
            if (pop) begin
                q_pc_d[0] = q_pc_q[1];
                q_ir_d[0] = q_ir_q[1];
            end
            if (push) begin
                q_pc_d[wr_pos[0]] = req_pc_q;
                q_ir_d[wr_pos[0]] = imem_rdata_i;
            end
            cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
            case (state_q)
                S_FETCH: if (issue) begin
                    state_d    = S_WAIT;
                    req_pc_d   = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + 16'd2;
                end
                S_WAIT:  if (imem_valid_i) state_d = S_FETCH;
                S_DROP:  if (imem_valid_i) state_d = S_FETCH;
                default: state_d = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= S_FETCH;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            cnt_q      <= 2'd0;
            q_pc_q[0]  <= 16'h0000;
            q_pc_q[1]  <= 16'h0000;
            q_ir_q[0]  <= 16'h0000;
            q_ir_q[1]  <= 16'h0000;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            cnt_q      <= cnt_d;
            q_pc_q     <= q_pc_d;
            q_ir_q     <= q_ir_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a behavioural instruction memory of
// programmable latency; data word = 16'h1111 * (addr[3:1] + 1).
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        jump = 1'b0;
    logic [15:0] new_pc = 16'h0000;
    logic        stall = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        mem_valid = 1'b0;
    logic        extra_valid = 1'b0;
    logic        imem_valid;
    logic [15:0] mem_rdata = 16'h0000;
    logic [15:0] pc_out, ir_out;
    logic        valid_out;

    int errs = 0;
    int nchk = 0;
    int lat  = 1;
    int mcnt = 0;
    int nreq = 0;
    logic [15:0] paddr = 16'h0000;

    assign imem_valid = mem_valid | extra_valid;

    fetch_stage #(.RESET_PC(16'h0000)) dut (
        .clk_i(clk), .reset_i(rst), .jump_i(jump), .new_pc_i(new_pc),
        .stall_i(stall), .imem_req_o(imem_req), .imem_addr_o(imem_addr),
        .imem_valid_i(imem_valid), .imem_rdata_i(mem_rdata),
        .pc_out_o(pc_out), .ir_out_o(ir_out), .valid_out_o(valid_out)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] dat(input logic [15:0] a);
        logic [15:0] k;
        k = {13'd0, a[3:1]} + 16'd1;
        return 16'h1111 * k;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            mcnt = 0;
            mem_valid = 1'b0;
        end else begin
            mem_valid = 1'b0;
            if (mcnt > 0) begin
                mcnt = mcnt - 1;
                if (mcnt == 0) begin
                    mem_valid = 1'b1;
                    mem_rdata = dat(paddr);
                end
            end
            if (imem_req) begin
                paddr = imem_addr;
                mcnt  = lat;
                nreq  = nreq + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
        nchk = nchk + 1;
        if (act !== exp) begin
            errs = errs + 1;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1 time unit into the first cycle after reset release.
    task automatic do_reset;
        rst = 1'b1; jump = 1'b0; stall = 1'b0; extra_valid = 1'b0;
        cyc; cyc;
        #1;
        chk("rst_valid", {15'd0, valid_out}, 16'd0);
        chk("rst_pc",    pc_out, 16'h0000);
        chk("rst_ir",    ir_out, 16'h0000);
        chk("rst_req",   {15'd0, imem_req}, 16'd0);
        chk("rst_addr",  imem_addr, 16'h0000);
        cyc;
        rst  = 1'b0;
        nreq = 0;
    endtask

    initial begin
        // Basic flow with 1-cycle memory
        lat = 1;
        do_reset;
        #1;
        chk("t1_req0",  {15'd0, imem_req}, 16'd1);
        chk("t1_addr0", imem_addr, 16'h0000);
        chk("t1_vo0",   {15'd0, valid_out}, 16'd0);
        cyc; #1;
        chk("t1_req1",  {15'd0, imem_req}, 16'd0);
        cyc; #1;
        chk("t1_vo2",   {15'd0, valid_out}, 16'd1);
        chk("t1_pc2",   pc_out, 16'h0000);
        chk("t1_ir2",   ir_out, 16'h1111);
        chk("t1_addr2", imem_addr, 16'h0002);
        cyc; #1;
        chk("t1_vo3",   {15'd0, valid_out}, 16'd0);
        cyc; #1;
        chk("t1_pc4",   pc_out, 16'h0002);
        chk("t1_ir4",   ir_out, 16'h2222);
        chk("t1_addr4", imem_addr, 16'h0004);
        chk("t1_req4",  {15'd0, imem_req}, 16'd1);

        // Back-pressure: stall for 10 cycles, stray valid while full is ignored
        lat = 1;
        do_reset;
        stall = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            cyc;
            extra_valid = (c == 5);
            #1;
            if (c >= 2) begin
                chk("t2_hold_pc", pc_out, 16'h0000);
                chk("t2_hold_ir", ir_out, 16'h1111);
            end
            if (c == 4) begin
                chk("t2_full_req",  {15'd0, imem_req}, 16'd0);
                chk("t2_full_addr", imem_addr, 16'h0004);
            end
        end
        chk("t2_nreq", nreq[15:0], 16'd2);
        cyc; stall = 1'b0; #1;
        chk("t2_d0_vo",  {15'd0, valid_out}, 16'd1);
        chk("t2_d0_pc",  pc_out, 16'h0000);
        chk("t2_d0_req", {15'd0, imem_req}, 16'd0);
        cyc; #1;
        chk("t2_d1_pc",   pc_out, 16'h0002);
        chk("t2_d1_ir",   ir_out, 16'h2222);
        chk("t2_d1_req",  {15'd0, imem_req}, 16'd1);
        chk("t2_d1_addr", imem_addr, 16'h0004);
        cyc; #1;
        chk("t2_d2_vo", {15'd0, valid_out}, 16'd0);
        cyc; #1;
        chk("t2_d3_pc", pc_out, 16'h0004);
        chk("t2_d3_ir", ir_out, 16'h3333);

        // Redirect while a 3-cycle read is outstanding
        lat = 3;
        do_reset;
        #1;
        chk("t3_req0", {15'd0, imem_req}, 16'd1);
        cyc; jump = 1'b1; new_pc = 16'h0040; #1;
        chk("t3_req1", {15'd0, imem_req}, 16'd0);
        cyc; jump = 1'b0; #1;
        chk("t3_addr2", imem_addr, 16'h0040);
        chk("t3_req2",  {15'd0, imem_req}, 16'd0);
        chk("t3_vo2",   {15'd0, valid_out}, 16'd0);
        cyc; #1;
        chk("t3_req3", {15'd0, imem_req}, 16'd0);
        cyc; lat = 1; #1;
        chk("t3_req4",  {15'd0, imem_req}, 16'd1);
        chk("t3_addr4", imem_addr, 16'h0040);
        chk("t3_vo4",   {15'd0, valid_out}, 16'd0);
        cyc; #1;
        chk("t3_vo5", {15'd0, valid_out}, 16'd0);
        cyc; #1;
        chk("t3_vo6", {15'd0, valid_out}, 16'd1);
        chk("t3_pc6", pc_out, 16'h0040);
        chk("t3_ir6", ir_out, 16'h1111);

        // Jump coinciding with a response and a pop
        lat = 1;
        do_reset;
        stall = 1'b1;
        cyc; cyc; #1;
        chk("t4_vo2", {15'd0, valid_out}, 16'd1);
        cyc; stall = 1'b0; jump = 1'b1; new_pc = 16'h0080; #1;
        chk("t4_req3", {15'd0, imem_req}, 16'd0);
        cyc; jump = 1'b0; #1;
        chk("t4_vo4",   {15'd0, valid_out}, 16'd0);
        chk("t4_pc4",   pc_out, 16'h0000);
        chk("t4_ir4",   ir_out, 16'h0000);
        chk("t4_req4",  {15'd0, imem_req}, 16'd1);
        chk("t4_addr4", imem_addr, 16'h0080);
        cyc; cyc; #1;
        chk("t4_pc6", pc_out, 16'h0080);
        chk("t4_ir6", ir_out, 16'h1111);

        // Address wrap-around
        lat = 1;
        do_reset;
        jump = 1'b1; new_pc = 16'hFFFE; #1;
        chk("t5_req0", {15'd0, imem_req}, 16'd0);
        cyc; jump = 1'b0; #1;
        chk("t5_req1",  {15'd0, imem_req}, 16'd1);
        chk("t5_addr1", imem_addr, 16'hFFFE);
        cyc; #1;
        chk("t5_addr2", imem_addr, 16'h0000);
        cyc; #1;
        chk("t5_pc3",   pc_out, 16'hFFFE);
        chk("t5_ir3",   ir_out, 16'h8888);
        chk("t5_addr3", imem_addr, 16'h0000);
        cyc; cyc; #1;
        chk("t5_pc5", pc_out, 16'h0000);
        chk("t5_ir5", ir_out, 16'h1111);

        // Reset asserted mid-operation, read outstanding, queue non-empty
        lat = 1;
        do_reset;
        stall = 1'b1;
        cyc; cyc; cyc; #1;
        chk("t6_vo3", {15'd0, valid_out}, 16'd1);
        rst = 1'b1; #1;
        chk("t6_rvo",   {15'd0, valid_out}, 16'd0);
        chk("t6_rpc",   pc_out, 16'h0000);
        chk("t6_rir",   ir_out, 16'h0000);
        chk("t6_rreq",  {15'd0, imem_req}, 16'd0);
        chk("t6_raddr", imem_addr, 16'h0000);
        cyc; rst = 1'b0; stall = 1'b0; #1;
        chk("t6_req",  {15'd0, imem_req}, 16'd1);
        chk("t6_addr", imem_addr, 16'h0000);
        cyc; cyc; #1;
        chk("t6_pc", pc_out, 16'h0000);
        chk("t6_ir", ir_out, 16'h1111);

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end

endmodule
